// File: rtl/pipeline_trace_gen.sv
// Trace producer: shadows the 5-stage pipeline slots and queues one record per retirement.
// Optional TRACE_FLUSH_EN: also emit a FLUSH record when a flush kills a valid instruction.
module pipeline_trace_gen #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned SEQ_W      = 8,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_if_valid,
  input  logic [PC_W-1:0]    i_if_pc,
  input  logic [INSTR_W-1:0] i_if_instr,
  input  logic               i_pc_stall,
  input  logic               i_if_id_stall,
  input  logic               i_if_flush,
  input  logic               i_id_flush,
  input  logic               i_wb_we,
  input  logic [3:0]         i_wb_addr,
  input  logic [15:0]        i_wb_data,
  output logic               o_tr_valid,
  input  logic               i_tr_ready,
  output logic [1:0]         o_tr_kind,
  output logic [SEQ_W-1:0]   o_tr_seq,
  output logic [CYC_W-1:0]   o_tr_cycle,
  output logic [PC_W-1:0]    o_tr_pc,
  output logic [INSTR_W-1:0] o_tr_instr,
  output logic               o_tr_we,
  output logic [3:0]         o_tr_waddr,
  output logic [15:0]        o_tr_wdata,
  output logic               o_tr_overflow,
  output logic [7:0]         o_drop_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } slot_t;

  typedef struct packed {
    logic [1:0]         kind;
    logic [SEQ_W-1:0]   seq;
    logic [CYC_W-1:0]   cycle;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               we;
    logic [3:0]         waddr;
    logic [15:0]        wdata;
  } rec_t;

  logic [CYC_W-1:0] r_cycle;
  logic [SEQ_W-1:0] r_seq;
  logic             r_ifid_v, r_idex_v, r_exmem_v, r_memwb_v;
  slot_t            r_ifid, r_idex, r_exmem, r_memwb;

  logic             w_accept;
  slot_t            w_fetch;

  assign w_accept = i_if_valid & ~i_pc_stall & ~i_if_id_stall;
  assign w_fetch  = '{seq: r_seq, instr: i_if_instr, pc: i_if_pc};

  // Shadow pipeline: flush beats stall beats advance; EX/MEM and MEM/WB never stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_seq     <= '0;
      r_ifid_v  <= 1'b0;
      r_idex_v  <= 1'b0;
      r_exmem_v <= 1'b0;
      r_memwb_v <= 1'b0;
      r_ifid    <= '0;
      r_idex    <= '0;
      r_exmem   <= '0;
      r_memwb   <= '0;
    end else begin
      r_cycle <= r_cycle + CYC_W'(1);
      if (w_accept) r_seq <= r_seq + SEQ_W'(1);
      if (i_if_flush) begin
        r_ifid_v <= 1'b0;
      end else if (!i_if_id_stall) begin
        r_ifid_v <= w_accept;
        r_ifid   <= w_fetch;
      end
      if (i_id_flush || i_if_id_stall) begin
        r_idex_v <= 1'b0;
      end else begin
        r_idex_v <= r_ifid_v;
        r_idex   <= r_ifid;
      end
      r_exmem_v <= r_idex_v;
      r_exmem   <= r_idex;
      r_memwb_v <= r_exmem_v;
      r_memwb   <= r_exmem;
    end
  end

`ifdef TRACE_FLUSH_EN
  logic  w_flush_v;
  slot_t w_flush_slot;

  // The IF/ID occupant is older than the word being fetched, so it wins the FLUSH record.
  always_comb begin
    w_flush_v    = 1'b0;
    w_flush_slot = r_ifid;
    if (r_ifid_v && ((i_id_flush && !i_if_id_stall) || (i_if_flush && i_if_id_stall))) begin
      w_flush_v = 1'b1;
    end else if (w_accept && i_if_flush) begin
      w_flush_v    = 1'b1;
      w_flush_slot = w_fetch;
    end
  end
`endif

  logic w_push_v;
  logic w_lost;
  rec_t w_rec;

  always_comb begin
    w_push_v = 1'b0;
    w_lost   = 1'b0;
    w_rec    = '0;
    if (r_memwb_v) begin
      w_push_v    = 1'b1;
      w_rec.kind  = 2'b00;
      w_rec.seq   = r_memwb.seq;
      w_rec.cycle = r_cycle;
      w_rec.pc    = r_memwb.pc;
      w_rec.instr = r_memwb.instr;
      w_rec.we    = i_wb_we;
      w_rec.waddr = i_wb_addr;
      w_rec.wdata = i_wb_data;
    end
`ifdef TRACE_FLUSH_EN
    else if (w_flush_v) begin
      w_push_v    = 1'b1;
      w_rec.kind  = 2'b01;
      w_rec.seq   = w_flush_slot.seq;
      w_rec.cycle = r_cycle;
      w_rec.pc    = w_flush_slot.pc;
      w_rec.instr = w_flush_slot.instr;
    end
    w_lost = r_memwb_v & w_flush_v;
`endif
  end

  rec_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic             w_full, w_pop, w_wr;
  logic [1:0]       w_drop_n;
  logic [8:0]       w_drop_sum;
  rec_t             w_head;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = o_tr_valid & i_tr_ready;
  // A pop frees the slot the push lands in, so a full FIFO still accepts on a pop cycle.
  assign w_wr       = w_push_v & (~w_full | w_pop);
  assign w_drop_n   = {1'b0, w_push_v & ~w_wr} + {1'b0, w_lost};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_rec;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop_n != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign o_tr_valid    = (r_count != '0);
  assign o_tr_kind     = w_head.kind;
  assign o_tr_seq      = w_head.seq;
  assign o_tr_cycle    = w_head.cycle;
  assign o_tr_pc       = w_head.pc;
  assign o_tr_instr    = w_head.instr;
  assign o_tr_we       = w_head.we;
  assign o_tr_waddr    = w_head.waddr;
  assign o_tr_wdata    = w_head.wdata;
  assign o_tr_overflow = r_overflow;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_pipeline_trace_gen.sv
// Directed bench for pipeline_trace_gen: retire latency, stall, flush, overflow, WB capture, reset.
module tb_pipeline_trace_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_if_valid, i_pc_stall, i_if_id_stall, i_if_flush, i_id_flush;
  logic [15:0] i_if_pc, i_if_instr;
  logic        i_wb_we;
  logic [3:0]  i_wb_addr;
  logic [15:0] i_wb_data;
  logic        i_tr_ready;
  logic        o_tr_valid, o_tr_we, o_tr_overflow;
  logic [1:0]  o_tr_kind;
  logic [7:0]  o_tr_seq, o_drop_cnt;
  logic [31:0] o_tr_cycle;
  logic [15:0] o_tr_pc, o_tr_instr, o_tr_wdata;
  logic [3:0]  o_tr_waddr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipeline_trace_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_if_valid    (i_if_valid),
    .i_if_pc       (i_if_pc),
    .i_if_instr    (i_if_instr),
    .i_pc_stall    (i_pc_stall),
    .i_if_id_stall (i_if_id_stall),
    .i_if_flush    (i_if_flush),
    .i_id_flush    (i_id_flush),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .o_tr_valid    (o_tr_valid),
    .i_tr_ready    (i_tr_ready),
    .o_tr_kind     (o_tr_kind),
    .o_tr_seq      (o_tr_seq),
    .o_tr_cycle    (o_tr_cycle),
    .o_tr_pc       (o_tr_pc),
    .o_tr_instr    (o_tr_instr),
    .o_tr_we       (o_tr_we),
    .o_tr_waddr    (o_tr_waddr),
    .o_tr_wdata    (o_tr_wdata),
    .o_tr_overflow (o_tr_overflow),
    .o_drop_cnt    (o_drop_cnt)
  );

  logic [94:0] w_act;
  assign w_act = {o_tr_kind, o_tr_seq, o_tr_cycle, o_tr_pc, o_tr_instr,
                  o_tr_we, o_tr_waddr, o_tr_wdata};

  function automatic logic [94:0] rec(input logic [1:0] k, input logic [7:0] s,
                                      input logic [31:0] c, input logic [15:0] pc,
                                      input logic [15:0] ins, input logic we,
                                      input logic [3:0] wa, input logic [15:0] wd);
    return {k, s, c, pc, ins, we, wa, wd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_if_valid = 1'b0; i_if_pc = '0; i_if_instr = '0;
    i_pc_stall = 1'b0; i_if_id_stall = 1'b0; i_if_flush = 1'b0; i_id_flush = 1'b0;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
  endtask

  // Leaves the bench just after reset release: the following cycle has cycle stamp 0.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    i_tr_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] ins);
    i_if_valid = 1'b1; i_if_pc = pc; i_if_instr = ins;
    tick();
    i_if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    i_tr_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if ({o_tr_valid, w_act, o_tr_overflow, o_drop_cnt} !== 105'd0)
      $display("FAIL reset_outputs got %h want 0", {o_tr_valid, w_act, o_tr_overflow, o_drop_cnt});
    else n_pass++;
    rst_n = 1'b1;
    tick();
    tick();
    n_total++;
    if ({o_tr_valid, o_tr_overflow, o_drop_cnt} !== 10'd0)
      $display("FAIL reset_idle got %h want 0", {o_tr_valid, o_tr_overflow, o_drop_cnt});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) fetch(16'(2 * i), 16'(16'h1000 + i));
    n_total++;
    if (o_tr_valid !== 1'b0) $display("FAIL b2b_early_valid got %b want 0", o_tr_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({o_tr_valid, w_act} !== {1'b1, rec(2'b00, 8'(i), 32'(4 + i), 16'(2 * i),
                                             16'(16'h1000 + i), 1'b0, 4'd0, 16'd0)})
        $display("FAIL b2b_rec%0d got %h want seq %0d cycle %0d", i, {o_tr_valid, w_act}, i, 4 + i);
      else n_pass++;
    end
    tick();
    n_total++;
    if (o_tr_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", o_tr_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [95:0] exp_v [6];
    do_reset();
    fetch(16'h0000, 16'h2000);
    fetch(16'h0002, 16'h2001);
    fetch(16'h0004, 16'h2002);
    i_if_valid = 1'b1; i_if_pc = 16'h0006; i_if_instr = 16'h2003; i_if_id_stall = 1'b1;
    tick();
    i_if_id_stall = 1'b0;
    tick();
    i_if_valid = 1'b0;
    exp_v[0] = {1'b1, rec(2'b00, 8'd0, 32'd4, 16'h0000, 16'h2000, 1'b0, 4'd0, 16'd0)};
    exp_v[1] = {1'b1, rec(2'b00, 8'd1, 32'd5, 16'h0002, 16'h2001, 1'b0, 4'd0, 16'd0)};
    exp_v[2] = 96'd0;
    exp_v[3] = {1'b1, rec(2'b00, 8'd2, 32'd7, 16'h0004, 16'h2002, 1'b0, 4'd0, 16'd0)};
    exp_v[4] = {1'b1, rec(2'b00, 8'd3, 32'd8, 16'h0006, 16'h2003, 1'b0, 4'd0, 16'd0)};
    exp_v[5] = 96'd0;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (exp_v[i][95]) begin
        if ({o_tr_valid, w_act} !== exp_v[i])
          $display("FAIL stall_cyc%0d got %h want %h", i, {o_tr_valid, w_act}, exp_v[i]);
        else n_pass++;
      end else begin
        if (o_tr_valid !== 1'b0) $display("FAIL stall_gap%0d got %b want 0", i, o_tr_valid);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    fetch(16'h0006, 16'h3000);
    fetch(16'h0008, 16'h3001);
    i_if_valid = 1'b1; i_if_pc = 16'h000A; i_if_instr = 16'h3002;
    i_if_flush = 1'b1; i_id_flush = 1'b1;
    tick();
    idle_inputs();
    n_total++;
`ifdef TRACE_FLUSH_EN
    if ({o_tr_valid, w_act} !== {1'b1, rec(2'b01, 8'd1, 32'd2, 16'h0008, 16'h3001,
                                           1'b0, 4'd0, 16'd0)})
      $display("FAIL flush_record got %h want FLUSH pc 0008 seq 1", {o_tr_valid, w_act});
    else n_pass++;
`else
    if (o_tr_valid !== 1'b0) $display("FAIL flush_silent got %b want 0", o_tr_valid);
    else n_pass++;
`endif
    tick();
    n_total++;
    if (o_tr_valid !== 1'b0) $display("FAIL flush_gap got %b want 0", o_tr_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({o_tr_valid, w_act} !== {1'b1, rec(2'b00, 8'd0, 32'd4, 16'h0006, 16'h3000,
                                           1'b0, 4'd0, 16'd0)})
      $display("FAIL flush_survivor got %h want pc 0006 seq 0", {o_tr_valid, w_act});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (o_tr_valid !== 1'b0) $display("FAIL flush_no_retire%0d got %b want 0", i, o_tr_valid);
      else n_pass++;
    end
    n_total++;
    if ({o_tr_overflow, o_drop_cnt} !== 9'd0)
      $display("FAIL flush_no_drop got %h want 0", {o_tr_overflow, o_drop_cnt});
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    i_tr_ready = 1'b0;
    for (int i = 0; i < 6; i++) fetch(16'(16'h0010 + 2 * i), 16'(16'h4000 + i));
    tick();
    tick();
    n_total++;
    if ({o_tr_overflow, o_drop_cnt} !== 9'd0)
      $display("FAIL ovf_before got %h want 0", {o_tr_overflow, o_drop_cnt});
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({o_tr_valid, o_tr_overflow, o_drop_cnt} !== {1'b1, 1'b1, 8'd2})
      $display("FAIL ovf_after got %h want 1/1/02", {o_tr_valid, o_tr_overflow, o_drop_cnt});
    else n_pass++;
    i_tr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({o_tr_valid, w_act} !== {1'b1, rec(2'b00, 8'(i), 32'(4 + i), 16'(16'h0010 + 2 * i),
                                             16'(16'h4000 + i), 1'b0, 4'd0, 16'd0)})
        $display("FAIL ovf_drain%0d got %h want seq %0d", i, {o_tr_valid, w_act}, i);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({o_tr_valid, o_tr_overflow, o_drop_cnt} !== {1'b0, 1'b1, 8'd2})
      $display("FAIL ovf_empty got %h want 0/1/02", {o_tr_valid, o_tr_overflow, o_drop_cnt});
    else n_pass++;
  endtask

  task automatic test_wb_capture();
    do_reset();
    fetch(16'h0020, 16'h0112);
    tick();
    tick();
    i_wb_we = 1'b1; i_wb_addr = 4'd7; i_wb_data = 16'hFFFF;
    tick();
    i_wb_we = 1'b1; i_wb_addr = 4'd1; i_wb_data = 16'h0008;
    tick();
    i_wb_we = 1'b0; i_wb_addr = 4'd0; i_wb_data = 16'h0000;
    n_total++;
    if ({o_tr_valid, w_act} !== {1'b1, rec(2'b00, 8'd0, 32'd4, 16'h0020, 16'h0112,
                                           1'b1, 4'd1, 16'h0008)})
      $display("FAIL wb_capture got %h want we 1 addr 1 data 0008", {o_tr_valid, w_act});
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    i_tr_ready = 1'b0;
    fetch(16'h0030, 16'h5000);
    fetch(16'h0032, 16'h5001);
    fetch(16'h0034, 16'h5002);
    fetch(16'h0036, 16'h5003);
    tick();
    tick();
    tick();
    n_total++;
    if ({o_tr_valid, o_tr_seq} !== {1'b1, 8'd0})
      $display("FAIL rst_mid_pre got %h want 1/00", {o_tr_valid, o_tr_seq});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_tr_valid, w_act, o_tr_overflow, o_drop_cnt} !== 105'd0)
      $display("FAIL rst_mid_async got %h want 0", {o_tr_valid, w_act, o_tr_overflow, o_drop_cnt});
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    i_tr_ready = 1'b1;
    fetch(16'h0040, 16'h6000);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (o_tr_valid !== 1'b0) $display("FAIL rst_mid_stale%0d got %b want 0", i, o_tr_valid);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({o_tr_valid, w_act} !== {1'b1, rec(2'b00, 8'd0, 32'd4, 16'h0040, 16'h6000,
                                           1'b0, 4'd0, 16'd0)})
      $display("FAIL rst_mid_restart got %h want seq 0 cycle 4", {o_tr_valid, w_act});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_overflow();
    test_wb_capture();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
